// File: rtl/detector_colision_pkg.sv
// ---------------------------------------------------------------------------
// detector_colision_pkg
// Shared definitions for the collision detector and other game blocks:
//   state_t        FSM encoding (ARMED=0, HIT=1, INVULN=2, OVER=3)
//   V_VISIBLE_DEF  default first non-visible scan line (frame boundary)
//   cnt_width()    counter width for a count parameter, never below 1 bit
// ---------------------------------------------------------------------------
package detector_colision_pkg;

  typedef enum logic [1:0] {
    ARMED  = 2'd0,
    HIT    = 2'd1,
    INVULN = 2'd2,
    OVER   = 2'd3
  } state_t;

  localparam int unsigned V_VISIBLE_DEF = 480;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/detector_colision_cuadro.sv
// ---------------------------------------------------------------------------
// detector_cuadro
// Frame boundary detector. Pulses o_frame_tick for one clk on the first clk
// where i_pix_y equals V_VISIBLE. The previous pix_y is registered so the
// pulse happens once per frame, however many clks each scan line lasts.
// Ports:
//   clk           system clock
//   reset         asynchronous, active-low reset
//   i_pix_y       current scan line
//   o_frame_tick  one-clk pulse at the start of the vertical blanking
// ---------------------------------------------------------------------------
module detector_cuadro
  import detector_colision_pkg::*;
#(
  parameter int unsigned V_VISIBLE = V_VISIBLE_DEF,
  parameter int unsigned Y_W       = 10
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [Y_W-1:0] i_pix_y,
  output logic           o_frame_tick
);

  localparam logic [Y_W-1:0] Y_EDGE = Y_W'(V_VISIBLE);

  logic [Y_W-1:0] r_prev_y;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_prev_y <= '0;
    else        r_prev_y <= i_pix_y;
  end

  assign o_frame_tick = (i_pix_y == Y_EDGE) && (r_prev_y != Y_EDGE);

endmodule

// File: rtl/detector_colision.sv
// ---------------------------------------------------------------------------
// detector_colision
// Player/wall/goal collision detector for the maze game.
// Overlaps are accumulated over a frame and evaluated once per frame at the
// frame tick. A wall hit raises `hit` for HIT_CYCLES clks (its falling edge
// decrements the life counter), followed by INV_FRAMES frames of
// invulnerability. game_over parks the FSM in OVER until reset.
// Optional feature (macro META_DETECT_EN): goal detection, pulsing
// level_done for one clk when the player reaches the goal without touching
// a wall in the same frame. Without it level_done is tied low.
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   video_on, pix_x, pix_y     sync generator outputs
//   jugador_on, pared_on,
//   meta_on                    player / wall / goal pixel flags
//   game_over                  lives exhausted
//   hit, invulnerable,
//   level_done                 registered status outputs
// ---------------------------------------------------------------------------
module detector_colision
  import detector_colision_pkg::*;
#(
  parameter int unsigned V_VISIBLE  = V_VISIBLE_DEF,
  parameter int unsigned HIT_CYCLES = 16,
  parameter int unsigned INV_FRAMES = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       video_on,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic       jugador_on,
  input  logic       pared_on,
  input  logic       meta_on,
  input  logic       game_over,
  output logic       hit,
  output logic       invulnerable,
  output logic       level_done
);

  localparam int unsigned HC_W = cnt_width(HIT_CYCLES);
  localparam int unsigned IF_W = cnt_width(INV_FRAMES);
  localparam logic [HC_W-1:0] HC_LOAD = HC_W'(HIT_CYCLES - 1);
  localparam logic [IF_W-1:0] IF_LOAD = IF_W'(INV_FRAMES - 1);

  state_t          r_state, w_state_nxt;
  logic [HC_W-1:0] r_hit_cnt, w_hit_cnt_nxt;
  logic [IF_W-1:0] r_inv_cnt, w_inv_cnt_nxt;
  logic            r_col_pared;
  logic            r_hit, r_inv;
  logic            w_hit_nxt, w_inv_nxt;
  logic            w_frame_tick;
  logic            w_ov_pared;
  logic            w_goal;
  logic            w_goal_evt;
  logic            w_unused;

  detector_cuadro #(
    .V_VISIBLE (V_VISIBLE),
    .Y_W       (10)
  ) u_cuadro (
    .clk          (clk),
    .reset        (reset),
    .i_pix_y      (pix_y),
    .o_frame_tick (w_frame_tick)
  );

  assign w_ov_pared = video_on & jugador_on & pared_on;

  // On the tick the flag restarts from the current overlap, so an overlap
  // coinciding with the tick belongs to the next frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)            r_col_pared <= 1'b0;
    else if (w_frame_tick) r_col_pared <= w_ov_pared;
    else                   r_col_pared <= r_col_pared | w_ov_pared;
  end

`ifdef META_DETECT_EN
  logic w_ov_meta;
  logic r_col_meta;
  logic r_level_done;

  assign w_ov_meta = video_on & jugador_on & meta_on;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)            r_col_meta <= 1'b0;
    else if (w_frame_tick) r_col_meta <= w_ov_meta;
    else                   r_col_meta <= r_col_meta | w_ov_meta;
  end

  // A wall touch in the same frame cancels the goal.
  assign w_goal = r_col_meta & ~r_col_pared;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_level_done <= 1'b0;
    else        r_level_done <= w_goal_evt;
  end

  assign level_done = r_level_done;
  assign w_unused   = ^pix_x;
`else
  assign w_goal     = 1'b0;
  assign level_done = 1'b0;
  assign w_unused   = ^{pix_x, meta_on, w_goal_evt};
`endif

  // State register and counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ARMED;
      r_hit_cnt <= '0;
      r_inv_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_hit_cnt <= w_hit_cnt_nxt;
      r_inv_cnt <= w_inv_cnt_nxt;
    end
  end

  // Next-state logic; counters only decrement from non-zero.
  always_comb begin
    w_state_nxt   = r_state;
    w_hit_cnt_nxt = r_hit_cnt;
    w_inv_cnt_nxt = r_inv_cnt;
    w_goal_evt    = 1'b0;
    if (game_over) begin
      w_state_nxt = OVER;
    end else begin
      case (r_state)
        ARMED: begin
          if (w_frame_tick) begin
            if (r_col_pared) begin
              w_state_nxt   = HIT;
              w_hit_cnt_nxt = HC_LOAD;
            end else if (w_goal) begin
              w_goal_evt = 1'b1;
            end
          end
        end
        HIT: begin
          if (r_hit_cnt == '0) begin
            w_state_nxt   = INVULN;
            w_inv_cnt_nxt = IF_LOAD;
          end else begin
            w_hit_cnt_nxt = r_hit_cnt - 1'b1;
          end
        end
        INVULN: begin
          // Wall overlaps are ignored here; only the goal can cut it short.
          if (w_frame_tick) begin
            if (w_goal) begin
              w_goal_evt    = 1'b1;
              w_state_nxt   = ARMED;
              w_inv_cnt_nxt = '0;
            end else if (r_inv_cnt == '0) begin
              w_state_nxt = ARMED;
            end else begin
              w_inv_cnt_nxt = r_inv_cnt - 1'b1;
            end
          end
        end
        OVER:    w_state_nxt = OVER;
        default: w_state_nxt = ARMED;
      endcase
    end
  end

  // Outputs decoded from the next state, then registered, so they change
  // on the same edge as the state and have no input-to-output path.
  always_comb begin
    w_hit_nxt = (w_state_nxt == HIT);
    w_inv_nxt = (w_state_nxt == HIT) || (w_state_nxt == INVULN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hit <= 1'b0;
      r_inv <= 1'b0;
    end else begin
      r_hit <= w_hit_nxt;
      r_inv <= w_inv_nxt;
    end
  end

  assign hit          = r_hit;
  assign invulnerable = r_inv;

endmodule
